rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Registered RISC-V RV32I(+optional M) main decoder with valid/ready handshake on both sides.
- Successor to the R-type-only control unit: covers R, I-ALU, LOAD, STORE, BRANCH and LUI opcodes, and emits full datapath controls.
- Flags illegal encodings and keeps a saturating illegal-instruction counter.
- Sits between instruction fetch and the execute stage of the user-project core.

Parameters:
- ALUCTL_W, 4, width of alu_control (minimum 4).
- ENABLE_M, 1, 1 = decode MUL (funct7=0000001, funct3=000); 0 = that encoding is illegal.
- CNT_W, 8, width of illegal_cnt.

Ports:
- wb_clk_i  input  1  single clock, rising edge.
- wb_rst_ni  input  1  asynchronous active-low reset.
- in_valid  input  1  instr is valid.
- in_ready  output  1  stage accepts instr this cycle.
- instr  input  32  instruction: funct7=[31:25], funct3=[14:12], opcode=[6:0].
- out_valid  output  1  decoded controls valid.
- out_ready  input  1  downstream accepts outputs.
- alu_control  output  ALUCTL_W  ALU operation code.
- regwrite  output  1  write rd.
- memread  output  1  load.
- memwrite  output  1  store.
- branch  output  1  conditional branch.
- alusrc  output  1  0 = rs2 operand, 1 = immediate.
- illegal  output  1  decoded instruction is illegal.
- clear_cnt  input  1  synchronous clear of illegal_cnt.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0; all control outputs=0; alu_control=0; illegal=0; illegal_cnt=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept, output registers load the decode of instr and out_valid=1 next cycle. Latency is 1 cycle.
  - If out_valid && !out_ready, all outputs hold stable.
  - If out_ready && !accept, out_valid clears to 0; other outputs may hold.
  - Back-to-back throughput is 1 instruction per cycle when out_ready=1.
- ALU codes:
  - AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0100, SRL 0101, MUL 0110, XOR 0111, SLT 1000, SRA 1001, SLTU 1010.
  - Codes are zero-extended to ALUCTL_W.
- R-type (0110011): regwrite=1, alusrc=0.
  - funct7=0: funct3 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND.
  - funct7=0100000: funct3 0 SUB, 5 SRA.
  - funct7=0000001, funct3=0, ENABLE_M=1: MUL.
  - Any other combination is illegal.
- I-ALU (0010011): regwrite=1, alusrc=1.
  - funct3 maps as R-type with funct7 ignored, except for shifts.
  - Shifts: funct3=1 requires funct7=0. funct3=5 requires funct7 = 0 (SRL) or 0100000 (SRA); any other funct7 is illegal.
- LOAD (0000011): funct3 ∈ {0,1,2,4,5}; regwrite=1, memread=1, alusrc=1, ADD.
- STORE (0100011): funct3 ∈ {0,1,2}; memwrite=1, alusrc=1, ADD.
- BRANCH (1100011): funct3 ∈ {0,1,4,5,6,7}; branch=1, alusrc=0, SUB.
- LUI (0110111): regwrite=1, alusrc=1, ADD.
- Illegal (any other opcode, or a disallowed funct field):
  - illegal=1; regwrite, memread, memwrite, branch, alusrc all 0; alu_control=0.
  - The instruction is still passed through the handshake.
- illegal_cnt:
  - Increments by 1 on each accept of an illegal instr.
  - Saturates at all-ones.
  - clear_cnt=1 forces 0 next cycle and has priority over a simultaneous increment.
- Reset mid-stall: the pending output is discarded and out_valid=0.

Test Plan:
- Reset, then stream 0x003100B3 (add), 0x403100B3 (sub), 0x023100B3 (mul) with out_ready=1 -> one cycle after each accept, alu_control = 0010, 0100, 0110; regwrite=1, alusrc=0, illegal=0. Throughput is 1 per cycle.
- 0x00012083 (lw) then 0x00312023 (sw) -> lw: memread=1, regwrite=1, alusrc=1, ADD. sw: memwrite=1, regwrite=0, alusrc=1, ADD.
- 0x00000063 (beq) -> branch=1, alu_control=0100, regwrite=0. Then 0x40315093 (srai) -> 1001, alusrc=1.
- Hold out_ready=0 with in_valid=1 for 3 cycles -> in_ready=0 after the first accept, outputs stable. Release -> the next instr appears the following cycle, none lost or duplicated.
- Send 0x00000000 then 0x023100B3 with ENABLE_M=0 -> illegal=1 both times, all controls 0, illegal_cnt=2. Pulse clear_cnt together with an illegal accept -> illegal_cnt=0.
- CNT_W=2: accept 5 illegal instrs -> illegal_cnt=3. Assert wb_rst_ni=0 mid-stall -> out_valid and illegal_cnt go to 0 immediately.

Source files
------------

// File: rtl/rv_decode_stage.sv
// Registered RV32I(+M) main decoder with valid/ready handshake on both sides.
// Produces datapath controls one cycle after accept and counts illegal instructions.
module rv_decode_stage #(
   parameter int unsigned ALUCTL_W = 4,
   parameter bit          ENABLE_M = 1'b1,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         instr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ALUCTL_W-1:0] alu_control,
   output logic                regwrite,
   output logic                memread,
   output logic                memwrite,
   output logic                branch,
   output logic                alusrc,
   output logic                illegal,
   input  logic                clear_cnt,
   output logic [CNT_W-1:0]    illegal_cnt
);

   typedef enum logic [3:0] {
      AluAnd  = 4'd0,
      AluOr   = 4'd1,
      AluAdd  = 4'd2,
      AluSll  = 4'd3,
      AluSub  = 4'd4,
      AluSrl  = 4'd5,
      AluMul  = 4'd6,
      AluXor  = 4'd7,
      AluSlt  = 4'd8,
      AluSra  = 4'd9,
      AluSltu = 4'd10
   } alu_op_e;

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLui    = 7'b0110111;

   localparam logic [6:0] F7Zero = 7'b0000000;
   localparam logic [6:0] F7Alt  = 7'b0100000;
   localparam logic [6:0] F7Mul  = 7'b0000001;

   // Base funct3 mapping shared by R-type (funct7=0) and I-ALU.
   function automatic alu_op_e f3_op(input logic [2:0] f3);
      alu_op_e op;
      unique case (f3)
         3'd0:    op = AluAdd;
         3'd1:    op = AluSll;
         3'd2:    op = AluSlt;
         3'd3:    op = AluSltu;
         3'd4:    op = AluXor;
         3'd5:    op = AluSrl;
         3'd6:    op = AluOr;
         default: op = AluAnd;
      endcase
      return op;
   endfunction

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   alu_op_e dec_alu;
   logic    dec_regwrite;
   logic    dec_memread;
   logic    dec_memwrite;
   logic    dec_branch;
   logic    dec_alusrc;
   logic    dec_illegal;

   always_comb begin
      dec_alu      = AluAnd;
      dec_regwrite = 1'b0;
      dec_memread  = 1'b0;
      dec_memwrite = 1'b0;
      dec_branch   = 1'b0;
      dec_alusrc   = 1'b0;
      dec_illegal  = 1'b0;

      case (opcode)
         OpR: begin
            dec_regwrite = 1'b1;
            if (funct7 == F7Zero) begin
               dec_alu = f3_op(funct3);
            end else if (funct7 == F7Alt && funct3 == 3'd0) begin
               dec_alu = AluSub;
            end else if (funct7 == F7Alt && funct3 == 3'd5) begin
               dec_alu = AluSra;
            end else if (ENABLE_M && funct7 == F7Mul && funct3 == 3'd0) begin
               dec_alu = AluMul;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OpImm: begin
            dec_regwrite = 1'b1;
            dec_alusrc   = 1'b1;
            dec_alu      = f3_op(funct3);
            // funct7 only qualifies the shift-immediate forms.
            if (funct3 == 3'd1 && funct7 != F7Zero) begin
               dec_illegal = 1'b1;
            end else if (funct3 == 3'd5 && funct7 == F7Alt) begin
               dec_alu = AluSra;
            end else if (funct3 == 3'd5 && funct7 != F7Zero) begin
               dec_illegal = 1'b1;
            end
         end
         OpLoad: begin
            dec_regwrite = 1'b1;
            dec_memread  = 1'b1;
            dec_alusrc   = 1'b1;
            dec_alu      = AluAdd;
            if (!(funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) dec_illegal = 1'b1;
         end
         OpStore: begin
            dec_memwrite = 1'b1;
            dec_alusrc   = 1'b1;
            dec_alu      = AluAdd;
            if (funct3 > 3'd2) dec_illegal = 1'b1;
         end
         OpBranch: begin
            dec_branch = 1'b1;
            dec_alu    = AluSub;
            if (funct3 == 3'd2 || funct3 == 3'd3) dec_illegal = 1'b1;
         end
         OpLui: begin
            dec_regwrite = 1'b1;
            dec_alusrc   = 1'b1;
            dec_alu      = AluAdd;
         end
         default: dec_illegal = 1'b1;
      endcase

      // Illegal encodings travel down the pipe as bubbles with only the flag set.
      if (dec_illegal) begin
         dec_alu      = AluAnd;
         dec_regwrite = 1'b0;
         dec_memread  = 1'b0;
         dec_memwrite = 1'b0;
         dec_branch   = 1'b0;
         dec_alusrc   = 1'b0;
      end
   end

   logic                accept;
   logic [ALUCTL_W-1:0] alu_ext;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign alu_ext  = ALUCTL_W'(dec_alu);

   logic                valid_q;
   logic [ALUCTL_W-1:0] alu_q;
   logic                regwrite_q;
   logic                memread_q;
   logic                memwrite_q;
   logic                branch_q;
   logic                alusrc_q;
   logic                illegal_q;
   logic [CNT_W-1:0]    cnt_q;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         valid_q    <= 1'b0;
         alu_q      <= '0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         branch_q   <= 1'b0;
         alusrc_q   <= 1'b0;
         illegal_q  <= 1'b0;
      end else if (accept) begin
         valid_q    <= 1'b1;
         alu_q      <= alu_ext;
         regwrite_q <= dec_regwrite;
         memread_q  <= dec_memread;
         memwrite_q <= dec_memwrite;
         branch_q   <= dec_branch;
         alusrc_q   <= dec_alusrc;
         illegal_q  <= dec_illegal;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cnt_q <= '0;
      end else if (clear_cnt) begin
         cnt_q <= '0;
      end else if (accept && dec_illegal && cnt_q != {CNT_W{1'b1}}) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign out_valid   = valid_q;
   assign alu_control = alu_q;
   assign regwrite    = regwrite_q;
   assign memread     = memread_q;
   assign memwrite    = memwrite_q;
   assign branch      = branch_q;
   assign alusrc      = alusrc_q;
   assign illegal     = illegal_q;
   assign illegal_cnt = cnt_q;

   // A stalled output must not change until the consumer takes it.
   assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
      (out_valid && !out_ready) |=> (out_valid && $stable(alu_control) && $stable(regwrite)
         && $stable(memread) && $stable(memwrite) && $stable(branch) && $stable(alusrc)
         && $stable(illegal)));

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed vector table, stall/reset sequences and
// randomized traffic scored against a table-based decode model.
module tb_rv_decode_stage;

   typedef struct packed {
      logic [3:0] alu;
      logic       rw;
      logic       mr;
      logic       mw;
      logic       br;
      logic       src;
      logic       ill;
   } ctl_t;

   typedef struct {
      logic [31:0] ins;
      ctl_t        exp;
      string       nm;
   } vec_t;

   localparam ctl_t IllCtl = 10'b0000_000001;

   logic clk;
   logic rst_n1, rst_n2;

   // DUT 1: default parameters (M enabled, 8-bit counter)
   logic        iv1, ir1, ov1, or1, clr1;
   logic [31:0] in1;
   logic [3:0]  alu1;
   logic        rw1, mr1, mw1, br1, src1, ill1;
   logic [7:0]  cnt1;

   // DUT 2: M disabled, 2-bit counter, widened ALU code
   logic        iv2, ir2, ov2, or2, clr2;
   logic [31:0] in2;
   logic [4:0]  alu2;
   logic        rw2, mr2, mw2, br2, src2, ill2;
   logic [1:0]  cnt2;

   rv_decode_stage dut1 (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n1),
      .in_valid   (iv1),
      .in_ready   (ir1),
      .instr      (in1),
      .out_valid  (ov1),
      .out_ready  (or1),
      .alu_control(alu1),
      .regwrite   (rw1),
      .memread    (mr1),
      .memwrite   (mw1),
      .branch     (br1),
      .alusrc     (src1),
      .illegal    (ill1),
      .clear_cnt  (clr1),
      .illegal_cnt(cnt1)
   );

   rv_decode_stage #(
      .ALUCTL_W(5),
      .ENABLE_M(1'b0),
      .CNT_W   (2)
   ) dut2 (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n2),
      .in_valid   (iv2),
      .in_ready   (ir2),
      .instr      (in2),
      .out_valid  (ov2),
      .out_ready  (or2),
      .alu_control(alu2),
      .regwrite   (rw2),
      .memread    (mr2),
      .memwrite   (mw2),
      .branch     (br2),
      .alusrc     (src2),
      .illegal    (ill2),
      .clear_cnt  (clr2),
      .illegal_cnt(cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // Decode model built from the opcode rules and lookup tables.
   function automatic ctl_t model_dec(input logic [31:0] ins, input bit en_m);
      logic [3:0] base [8];
      ctl_t       e;
      bit         ok;
      int         f3;
      int         f7;
      base = '{4'b0010, 4'b0011, 4'b1000, 4'b1010, 4'b0111, 4'b0101, 4'b0001, 4'b0000};
      e  = '0;
      ok = 1'b0;
      f3 = int'(ins[14:12]);
      f7 = int'(ins[31:25]);
      case (ins[6:0])
         7'h33: begin
            e.rw = 1'b1;
            if (f7 == 0) begin ok = 1'b1; e.alu = base[f3]; end
            else if (f7 == 32 && f3 == 0) begin ok = 1'b1; e.alu = 4'b0100; end
            else if (f7 == 32 && f3 == 5) begin ok = 1'b1; e.alu = 4'b1001; end
            else if (f7 == 1 && f3 == 0 && en_m) begin ok = 1'b1; e.alu = 4'b0110; end
         end
         7'h13: begin
            e.rw = 1'b1; e.src = 1'b1; e.alu = base[f3];
            ok = !((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32));
            if (f3 == 5 && f7 == 32) e.alu = 4'b1001;
         end
         7'h03: begin
            e.rw = 1'b1; e.mr = 1'b1; e.src = 1'b1; e.alu = 4'b0010;
            ok = (f3 != 3 && f3 != 6 && f3 != 7);
         end
         7'h23: begin
            e.mw = 1'b1; e.src = 1'b1; e.alu = 4'b0010;
            ok = (f3 <= 2);
         end
         7'h63: begin
            e.br = 1'b1; e.alu = 4'b0100;
            ok = (f3 != 2 && f3 != 3);
         end
         7'h37: begin
            e.rw = 1'b1; e.src = 1'b1; e.alu = 4'b0010; ok = 1'b1;
         end
         default: ok = 1'b0;
      endcase
      if (!ok) e = IllCtl;
      return e;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0: r[6:0] = 7'h33;
         1: r[6:0] = 7'h13;
         2: r[6:0] = 7'h03;
         3: r[6:0] = 7'h23;
         4: r[6:0] = 7'h63;
         5: r[6:0] = 7'h37;
         default: ;
      endcase
      case ($urandom_range(0, 3))
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         2: r[31:25] = 7'h01;
         default: ;
      endcase
      return r;
   endfunction

   vec_t vecs[18];
   ctl_t q[$];
   int   mcnt;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      vecs[0]  = '{32'h003100B3, 10'b0010_100000, "add"};
      vecs[1]  = '{32'h403100B3, 10'b0100_100000, "sub"};
      vecs[2]  = '{32'h023100B3, 10'b0110_100000, "mul"};
      vecs[3]  = '{32'h00012083, 10'b0010_110010, "lw"};
      vecs[4]  = '{32'h00312023, 10'b0010_001010, "sw"};
      vecs[5]  = '{32'h00000063, 10'b0100_000100, "beq"};
      vecs[6]  = '{32'h40315093, 10'b1001_100010, "srai"};
      vecs[7]  = '{32'h000000B7, 10'b0010_100010, "lui"};
      vecs[8]  = '{32'h00000000, 10'b0000_000001, "zero_ill"};
      vecs[9]  = '{32'h02001093, 10'b0000_000001, "slli_f7_ill"};
      vecs[10] = '{32'h00314093, 10'b0111_100010, "xori"};
      vecs[11] = '{32'hFE017093, 10'b0000_100010, "andi_f7_ignored"};
      vecs[12] = '{32'h00013083, 10'b0000_000001, "load_f3_ill"};
      vecs[13] = '{32'h40315033, 10'b1001_100000, "sra"};
      vecs[14] = '{32'h00002063, 10'b0000_000001, "branch_f3_ill"};
      vecs[15] = '{32'h00313033, 10'b1010_100000, "sltu"};
      vecs[16] = '{32'h00312013, 10'b1000_100010, "slti"};
      vecs[17] = '{32'h02015093, 10'b0000_000001, "srli_f7_ill"};

      rst_n1 = 1'b0; rst_n2 = 1'b0;
      iv1 = 1'b0; or1 = 1'b1; clr1 = 1'b0; in1 = '0;
      iv2 = 1'b0; or2 = 1'b1; clr2 = 1'b0; in2 = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", ov1, 0);
      chk("rst_ctl", {alu1, rw1, mr1, mw1, br1, src1, ill1}, 0);
      chk("rst_cnt", cnt1, 0);
      chk("rst_in_ready", ir1, 1);
      @(negedge clk);
      rst_n1 = 1'b1; rst_n2 = 1'b1;

      // Back-to-back vector table: each result appears the cycle after its accept
      for (int i = 0; i <= 18; i++) begin
         @(negedge clk);
         or1 = 1'b1;
         if (i < 18) begin iv1 = 1'b1; in1 = vecs[i].ins; end
         else iv1 = 1'b0;
         #1;
         if (i > 0) begin
            chk({"vec_valid_", vecs[i-1].nm}, ov1, 1);
            chk({"vec_", vecs[i-1].nm}, {alu1, rw1, mr1, mw1, br1, src1, ill1}, vecs[i-1].exp);
         end
      end
      @(negedge clk);
      #1 chk("vec_drain_valid", ov1, 0);

      // Stall for 3 cycles with a second instruction waiting
      @(negedge clk);
      iv1 = 1'b1; in1 = 32'h003100B3; or1 = 1'b0;
      @(negedge clk);
      in1 = 32'h403100B3;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_in_ready", ir1, 0);
         chk("stall_valid", ov1, 1);
         chk("stall_hold", {alu1, rw1, mr1, mw1, br1, src1, ill1}, 10'b0010_100000);
         @(negedge clk);
      end
      or1 = 1'b1;
      #1 chk("release_in_ready", ir1, 1);
      @(negedge clk);
      iv1 = 1'b0;
      #1;
      chk("release_valid", ov1, 1);
      chk("release_next", {alu1, rw1, mr1, mw1, br1, src1, ill1}, 10'b0100_100000);
      @(negedge clk);
      #1 chk("release_no_dup", ov1, 0);

      // Clear the counter so the model starts from zero
      clr1 = 1'b1;
      @(negedge clk);
      clr1 = 1'b0;
      mcnt = 0;
      q.delete();

      // Randomized traffic against the scoreboard
      for (int c = 0; c < 400; c++) begin
         logic acc;
         ctl_t e;
         @(negedge clk);
         iv1  = ($urandom_range(0, 3) != 0);
         in1  = rnd_instr();
         or1  = ($urandom_range(0, 3) != 0);
         clr1 = ($urandom_range(0, 19) == 0);
         #1;
         chk("rnd_valid", ov1, q.size() != 0);
         chk("rnd_in_ready", ir1, (q.size() == 0) || or1);
         chk("rnd_cnt", cnt1, mcnt);
         if (q.size() != 0) chk("rnd_ctl", {alu1, rw1, mr1, mw1, br1, src1, ill1}, q[0]);
         acc = iv1 && ((q.size() == 0) || or1);
         if (q.size() != 0 && or1) void'(q.pop_front());
         e = model_dec(in1, 1'b1);
         if (acc) q.push_back(e);
         if (clr1) mcnt = 0;
         else if (acc && e.ill && mcnt < 255) mcnt++;
      end
      @(negedge clk);
      iv1 = 1'b0; clr1 = 1'b0;

      // DUT 2: illegal zero word and MUL with M disabled
      @(negedge clk);
      iv2 = 1'b1; in2 = 32'h00000000; or2 = 1'b1;
      @(negedge clk);
      in2 = 32'h023100B3;
      #1 chk("m0_zero_ill", {alu2, rw2, mr2, mw2, br2, src2, ill2}, 11'b00000_000001);
      @(negedge clk);
      iv2 = 1'b0;
      #1;
      chk("m0_mul_ill", {alu2, rw2, mr2, mw2, br2, src2, ill2}, 11'b00000_000001);
      chk("m0_cnt2", cnt2, 2);

      // Clear wins over a simultaneous illegal accept
      @(negedge clk);
      iv2 = 1'b1; in2 = 32'h00000000; clr2 = 1'b1;
      @(negedge clk);
      iv2 = 1'b0; clr2 = 1'b0;
      #1 chk("clr_priority", cnt2, 0);

      // Saturation at all-ones on a 2-bit counter
      @(negedge clk);
      iv2 = 1'b1; in2 = 32'hFFFFFFFF;
      repeat (5) @(negedge clk);
      iv2 = 1'b0;
      #1 chk("cnt_saturate", cnt2, 3);

      // Reset asserted mid-stall
      @(negedge clk);
      iv2 = 1'b1; in2 = 32'h003100B3; or2 = 1'b0;
      @(negedge clk);
      iv2 = 1'b0;
      #1;
      chk("stall2_valid", ov2, 1);
      chk("stall2_in_ready", ir2, 0);
      chk("stall2_alu_zext", alu2, 5'b00010);
      #2 rst_n2 = 1'b0;
      #1;
      chk("midrst_valid", ov2, 0);
      chk("midrst_cnt", cnt2, 0);
      chk("midrst_ctl", {alu2, rw2, mr2, mw2, br2, src2, ill2}, 0);
      @(negedge clk);
      rst_n2 = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
